// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the counter scoring game
//
// Purpose : counter width default, counting-mode and outcome enums,
//           FSM state enum and the game-ending score.
// Ports   : none (package)
package game_pkg;

   localparam int WIDTH = 4;

   typedef enum logic [1:0] {
      UP_1   = 2'd0,
      UP_2   = 2'd1,
      DOWN_1 = 2'd2,
      DOWN_2 = 2'd3
   } ctrl_e;

   localparam logic [1:0] CTRL_UP_1   = 2'd0;
   localparam logic [1:0] CTRL_UP_2   = 2'd1;
   localparam logic [1:0] CTRL_DOWN_1 = 2'd2;
   localparam logic [1:0] CTRL_DOWN_2 = 2'd3;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      WIN  = 2'd1,
      LOSE = 2'd2
   } who_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_e;

   localparam logic [3:0] SCORE_MAX = 4'd15;

endpackage

// File: rtl/game.sv
// rtl/game.sv - up/down counter scoring game with win/lose tallies
//
// Purpose : WIDTH-bit counter loaded on INIT, stepped +1/+2/-1/-2 per CTRL.
//           Reaching all-ones scores a win, reaching zero scores a loss;
//           the first tally to hit 15 ends the game for one OVER cycle,
//           after which counter and tallies clear.
// Ports   : clk          - rising-edge clock
//           rst          - asynchronous active-low reset
//           CTRL         - counting mode
//           val          - load value
//           INIT         - load request
//           LOSER        - count is zero while playing
//           WINNER       - count is all-ones while playing
//           GAMEOVER     - one-cycle game-end flag
//           winner_score - number of wins
//           loser_score  - number of losses
//           WHO          - outcome of the last game
//           count        - current counter value
module game
   import game_pkg::*;
#(
   parameter int WIDTH = game_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  ctrl_e            CTRL,
   input  logic [WIDTH-1:0] val,
   input  logic             INIT,
   output logic             LOSER,
   output logic             WINNER,
   output logic             GAMEOVER,
   output logic [3:0]       winner_score,
   output logic [3:0]       loser_score,
   output who_e             WHO,
   output logic [WIDTH-1:0] count
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] stepped;
   logic [3:0]       win_q, win_d;
   logic [3:0]       lose_q, lose_d;
   who_e             who_q, who_d;

   // Flags are decoded straight from the count register so they line up
   // with the cycle in which the trigger value is visible.
   assign WINNER   = (state_q == S_PLAY) && (count_q == '1);
   assign LOSER    = (state_q == S_PLAY) && (count_q == '0);
   assign GAMEOVER = (state_q == S_OVER);

   assign count        = count_q;
   assign winner_score = win_q;
   assign loser_score  = lose_q;
   assign WHO          = who_q;

   // Modulo-2^WIDTH step; wrap is intentional and silent.
   always_comb begin
      stepped = count_q;
      case (CTRL)
         UP_1:    stepped = count_q + WIDTH'(1);
         UP_2:    stepped = count_q + WIDTH'(2);
         DOWN_1:  stepped = count_q - WIDTH'(1);
         DOWN_2:  stepped = count_q - WIDTH'(2);
         default: stepped = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      win_d   = win_q;
      lose_d  = lose_q;
      who_d   = who_q;
      case (state_q)
         S_IDLE: begin
            if (INIT) begin
               count_d = val;
               who_d   = NONE;
               state_d = S_PLAY;
            end
         end
         S_PLAY: begin
            count_d = INIT ? val : stepped;
            // WINNER and LOSER cannot both be set since WIDTH >= 2.
            if (WINNER) begin
               win_d = win_q + 4'd1;
               if (win_d == SCORE_MAX) begin
                  who_d   = WIN;
                  state_d = S_OVER;
               end
            end
            if (LOSER) begin
               lose_d = lose_q + 4'd1;
               if (lose_d == SCORE_MAX) begin
                  who_d   = LOSE;
                  state_d = S_OVER;
               end
            end
         end
         S_OVER: begin
            // INIT is ignored here; WHO survives the clear.
            count_d = '0;
            win_d   = 4'd0;
            lose_d  = 4'd0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         win_q   <= 4'd0;
         lose_q  <= 4'd0;
         who_q   <= NONE;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         win_q   <= win_d;
         lose_q  <= lose_d;
         who_q   <= who_d;
      end
   end

endmodule

// File: tb/tb_game.sv
// tb/tb_game.sv - directed self-checking bench for the game block
module tb_game;
   import game_pkg::*;

   logic       clk;
   logic       rst;
   ctrl_e      ctrl;
   logic [3:0] val;
   logic       init;
   logic       loser;
   logic       winner;
   logic       gameover;
   logic [3:0] winner_score;
   logic [3:0] loser_score;
   who_e       who;
   logic [3:0] count;

   int passed;
   int total;

   game #(.WIDTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .CTRL         (ctrl),
      .val          (val),
      .INIT         (init),
      .LOSER        (loser),
      .WINNER       (winner),
      .GAMEOVER     (gameover),
      .winner_score (winner_score),
      .loser_score  (loser_score),
      .WHO          (who),
      .count        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b0;
      init = 1'b0;
      #2;
      rst  = 1'b1;
      tick(1);
   endtask

   task automatic load(input logic [3:0] v, input ctrl_e c);
      val  = v;
      ctrl = c;
      init = 1'b1;
      tick(1);
      init = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; init = 1'b0; ctrl = UP_1; val = 4'd0;
      #3;
      total++;
      if ({count, winner_score, loser_score, winner, loser, gameover} !== 15'd0 || who !== NONE)
         $display("FAIL reset_state: count=%0d ws=%0d ls=%0d w=%b l=%b go=%b who=%0d required all zero/NONE",
                  count, winner_score, loser_score, winner, loser, gameover, who);
      else passed++;
      rst = 1'b1;
      tick(3);
      total++;
      if (count !== 4'd0 || loser !== 1'b0 || gameover !== 1'b0)
         $display("FAIL idle_hold: count=%0d loser=%b go=%b required 0/0/0", count, loser, gameover);
      else passed++;
   endtask

   task automatic test_up_1();
      do_reset();
      load(4'd3, UP_1);
      total++;
      if (count !== 4'd3) $display("FAIL up1_load: count=%0d required 3", count);
      else passed++;
      tick(12);
      total++;
      if (count !== 4'd15 || winner !== 1'b1 || loser !== 1'b0)
         $display("FAIL up1_winner: count=%0d winner=%b loser=%b required 15/1/0", count, winner, loser);
      else passed++;
      tick(1);
      total++;
      if (winner_score !== 4'd1 || count !== 4'd0 || loser !== 1'b1 || winner !== 1'b0)
         $display("FAIL up1_wrap: ws=%0d count=%0d loser=%b winner=%b required 1/0/1/0",
                  winner_score, count, loser, winner);
      else passed++;
      tick(1);
      total++;
      if (loser_score !== 4'd1 || count !== 4'd1)
         $display("FAIL up1_loss: ls=%0d count=%0d required 1/1", loser_score, count);
      else passed++;
   endtask

   task automatic test_async_reset();
      // Scores are 1/1 and the game is mid-play here.
      #2;
      rst = 1'b0;
      #1;
      total++;
      if ({count, winner_score, loser_score, winner, loser, gameover} !== 15'd0 || who !== NONE)
         $display("FAIL async_reset: count=%0d ws=%0d ls=%0d w=%b l=%b go=%b who=%0d required zero/NONE",
                  count, winner_score, loser_score, winner, loser, gameover, who);
      else passed++;
      rst  = 1'b1;
      ctrl = UP_2;
      tick(4);
      total++;
      if (count !== 4'd0 || loser !== 1'b0 || winner_score !== 4'd0)
         $display("FAIL post_reset_idle: count=%0d loser=%b ws=%0d required 0/0/0", count, loser, winner_score);
      else passed++;
   endtask

   task automatic test_up_2();
      int lose_seen;
      lose_seen = 0;
      do_reset();
      load(4'd3, UP_2);
      for (int i = 0; i < 16; i++) begin
         if (loser) lose_seen++;
         tick(1);
      end
      total++;
      if (count !== 4'd3 || winner_score !== 4'd2 || loser_score !== 4'd0 || lose_seen != 0)
         $display("FAIL up2_run: count=%0d ws=%0d ls=%0d loser_cycles=%0d required 3/2/0/0",
                  count, winner_score, loser_score, lose_seen);
      else passed++;
   endtask

   task automatic test_down_2();
      int win_seen;
      win_seen = 0;
      do_reset();
      load(4'd4, DOWN_2);
      tick(2);
      total++;
      if (count !== 4'd0 || loser !== 1'b1)
         $display("FAIL down2_zero: count=%0d loser=%b required 0/1", count, loser);
      else passed++;
      for (int i = 0; i < 14; i++) begin
         if (winner) win_seen++;
         tick(1);
      end
      total++;
      if (count !== 4'd4 || loser_score !== 4'd2 || winner_score !== 4'd0 || win_seen != 0)
         $display("FAIL down2_run: count=%0d ls=%0d ws=%0d winner_cycles=%0d required 4/2/0/0",
                  count, loser_score, winner_score, win_seen);
      else passed++;
   endtask

   task automatic test_mid_run();
      do_reset();
      load(4'd0, UP_1);
      tick(1);
      total++;
      if (count !== 4'd1) $display("FAIL mid_up1: count=%0d required 1", count);
      else passed++;
      ctrl = UP_2;   tick(1);
      total++;
      if (count !== 4'd3) $display("FAIL mid_up2: count=%0d required 3", count);
      else passed++;
      ctrl = DOWN_1; tick(1);
      total++;
      if (count !== 4'd2) $display("FAIL mid_down1: count=%0d required 2", count);
      else passed++;
      ctrl = DOWN_2; tick(1);
      total++;
      if (count !== 4'd0) $display("FAIL mid_down2: count=%0d required 0", count);
      else passed++;
      ctrl = UP_2; val = 4'd7; init = 1'b1;
      tick(1);
      init = 1'b0;
      total++;
      if (count !== 4'd7) $display("FAIL load_priority: count=%0d required 7", count);
      else passed++;
   endtask

   task automatic test_game_win();
      int cyc;
      do_reset();
      load(4'd3, UP_1);
      cyc = 0;
      while (gameover !== 1'b1 && cyc < 400) begin
         tick(1);
         cyc++;
      end
      total++;
      if (cyc != 237 || who !== WIN || winner_score !== 4'd15 || loser_score !== 4'd14 ||
          count !== 4'd0 || winner !== 1'b0 || loser !== 1'b0)
         $display("FAIL win_over: cycles=%0d who=%0d ws=%0d ls=%0d count=%0d w=%b l=%b required 237/1/15/14/0/0/0",
                  cyc, who, winner_score, loser_score, count, winner, loser);
      else passed++;
      val = 4'd9; init = 1'b1;
      tick(1);
      init = 1'b0;
      total++;
      if (gameover !== 1'b0 || count !== 4'd0 || winner_score !== 4'd0 || loser_score !== 4'd0 || who !== WIN)
         $display("FAIL win_clear: go=%b count=%0d ws=%0d ls=%0d who=%0d required 0/0/0/0/1",
                  gameover, count, winner_score, loser_score, who);
      else passed++;
      tick(2);
      total++;
      if (count !== 4'd0 || loser !== 1'b0 || gameover !== 1'b0)
         $display("FAIL win_idle: count=%0d loser=%b go=%b required 0/0/0", count, loser, gameover);
      else passed++;
   endtask

   task automatic test_game_lose();
      int cyc;
      do_reset();
      load(4'd3, DOWN_1);
      cyc = 0;
      while (gameover !== 1'b1 && cyc < 400) begin
         tick(1);
         cyc++;
      end
      total++;
      if (cyc != 228 || who !== LOSE || loser_score !== 4'd15 || winner_score !== 4'd14)
         $display("FAIL lose_over: cycles=%0d who=%0d ls=%0d ws=%0d required 228/2/15/14",
                  cyc, who, loser_score, winner_score);
      else passed++;
      tick(1);
      total++;
      if (who !== LOSE || gameover !== 1'b0 || loser_score !== 4'd0)
         $display("FAIL lose_hold: who=%0d go=%b ls=%0d required 2/0/0", who, gameover, loser_score);
      else passed++;
      load(4'd5, UP_1);
      total++;
      if (who !== NONE || count !== 4'd5)
         $display("FAIL new_game: who=%0d count=%0d required 0/5", who, count);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_up_1();
      test_async_reset();
      test_up_2();
      test_down_2();
      test_mid_run();
      test_game_win();
      test_game_lose();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/game.md
# game

Counter-based scoring game block. A WIDTH-bit counter is loaded with `val` on INIT and then steps up or down by 1 or 2 each clock, as selected by CTRL. Each arrival at all-ones scores a win and each arrival at zero scores a loss. The first 4-bit score to reach 15 ends the game: the block reports the outcome on GAMEOVER/WHO and then clears itself. It is a standalone leaf block driven directly by control logic.

## Interface
- Parameter `WIDTH`, default `game_pkg::WIDTH` = 4: counter width, minimum 2.
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, asynchronous and active-low.
- `CTRL` in 2 (`ctrl_e`): counting mode, sampled every clock.
- `val` in WIDTH: load value.
- `INIT` in 1: load request, sampled at the clock edge.
- `LOSER` out 1: count is zero while playing.
- `WINNER` out 1: count is all-ones while playing.
- `GAMEOVER` out 1: one-cycle game-end flag.
- `winner_score` out 4: number of wins.
- `loser_score` out 4: number of losses.
- `WHO` out `who_e`: winner of the last game.
- `count` out WIDTH: current counter value.

## Operation
- **Modes (CTRL):** UP_1=0 → +1, UP_2=1 → +2, DOWN_1=2 → −1, DOWN_2=3 → −2. Arithmetic is modulo 2^WIDTH; wrap is silent.
- **FSM states:** IDLE, PLAY, OVER.
- **IDLE:**
  - count, scores and WHO hold; LOSER=WINNER=GAMEOVER=0.
  - INIT=1: count←val, WHO←NONE, go to PLAY.
- **PLAY:**
  - INIT=1: count←val, and loading has priority over stepping.
  - Otherwise count steps per CTRL.
  - WINNER=(count=='1) and LOSER=(count==0), both combinational from the count register.
  - At the edge while WINNER=1: winner_score increments. If the new value is 15: WHO←WIN and go to OVER.
  - LOSER is symmetric: loser_score increments; if it reaches 15, WHO←LOSE and go to OVER.
  - WINNER and LOSER are mutually exclusive, since WIDTH≥2.
  - Counting continues on the edge that enters OVER.
- **OVER:**
  - GAMEOVER=1 and WINNER=LOSER=0.
  - INIT is ignored.
  - Next edge: count, winner_score and loser_score ←0, go to IDLE.
  - WHO holds until the next INIT from IDLE or reset.
- **Reset:** legal at any time, including mid-game or during OVER. It forces state=IDLE, count=0, both scores=0, GAMEOVER=LOSER=WINNER=0, WHO=NONE.

## Timing
- Load latency: count=val on the first edge with INIT=1.
- Step latency: one edge per step.
- WINNER/LOSER are valid in the same cycle count shows the trigger value. They remain high for as long as count holds that value. A held value scores once per cycle, which only happens with INIT reloading it.
- Score updates are visible one edge after the WINNER/LOSER cycle.
- GAMEOVER is high for exactly one cycle, beginning the edge after the 15th point. Everything is cleared one edge later.
- CTRL changes take effect on the next edge; there is no handshake.

## Structure
- Package `game_pkg` contains:
  - localparam WIDTH=4;
  - `ctrl_e` (2-bit: UP_1, UP_2, DOWN_1, DOWN_2) and CTRL constants;
  - `who_e` (2-bit: NONE=0, WIN=1, LOSE=2);
  - the state enum.
- One module, `game`. Optional sub-module `updown_counter` (load, step ±1/±2).

## Test plan
- **Reset:** reset asserted mid-play with scores nonzero → all outputs 0/NONE immediately, asynchronously, and IDLE holds until INIT.
- **UP_1 from val=3:** INIT → count=3; 12 edges later count=15 with WINNER=1; next edge winner_score=1, count=0, LOSER=1; one edge later loser_score=1.
- **UP_2 from val=3:** sequence 3,5,…,15,1,3,…; WINNER every 8 cycles; LOSER never fires; loser_score stays 0.
- **DOWN_2 from val=4:** sequence 4,2,0,14,…; LOSER every 8 cycles; WINNER never fires.
- **Game end (WIN):** UP_1 from val=3 until winner_score reaches 15 → WHO=WIN, GAMEOVER=1 for one cycle, then count=0, scores=0, FSM in IDLE. INIT during OVER is ignored.
- **Game end (LOSE):** DOWN_1 from val=3 until loser_score=15 → WHO=LOSE; a new INIT from IDLE sets WHO=NONE.
- **Mid-run changes:**
  - Switching CTRL (UP_1 → UP_2 → DOWN_1 → DOWN_2) mid-run changes the step on the next edge.
  - INIT together with a CTRL step: the load wins.
